// File: rtl/kmeans_pkg.sv
// Shared types for the k-means APB sequencer: register map, FSM states, limits.
package kmeans_pkg;

   localparam int KM_MAX_POINTS = 511;

   typedef enum logic [3:0] {
      REG_STATUS    = 4'd0,
      REG_GO        = 4'd1,
      REG_CENT1     = 4'd2,
      REG_CENT2     = 4'd3,
      REG_CENT3     = 4'd4,
      REG_CENT4     = 4'd5,
      REG_CENT5     = 4'd6,
      REG_CENT6     = 4'd7,
      REG_CENT7     = 4'd8,
      REG_CENT8     = 4'd9,
      REG_RAM_ADDR  = 4'd10,
      REG_RAM_DATA  = 4'd11,
      REG_FIRST_RAM = 4'd12,
      REG_LAST_RAM  = 4'd13
   } km_reg_e;

   typedef enum logic [3:0] {
      S_IDLE, S_CENT, S_FIRST, S_LAST, S_PT_ADDR, S_PT_DATA,
      S_GO, S_WAIT_IRQ, S_RD, S_OUT, S_DONE
   } km_state_e;

   typedef enum logic {ENG_SETUP, ENG_ACCESS} km_eng_e;

endpackage

// File: rtl/kmeans_apb_sequencer_if.sv
// APB bus between the sequencer (master) and k_means_top (slave).
interface kmeans_apb_sequencer_if #(
   parameter int addrWidth = 9,
   parameter int dataWidth = 91
);
   logic [addrWidth-1:0] paddr;
   logic                 pwrite;
   logic                 psel;
   logic                 penable;
   logic [dataWidth-1:0] pwdata;
   logic [dataWidth-1:0] prdata;
   logic                 pready;

   modport master (output paddr, pwrite, psel, penable, pwdata, input prdata, pready);
   modport slave  (input paddr, pwrite, psel, penable, pwdata, output prdata, pready);
endinterface

// File: rtl/kmeans_apb_master.sv
// Single-transfer APB engine: a request seen while idle is the setup cycle itself,
// then the access phase is held until pready.
module kmeans_apb_master
   import kmeans_pkg::*;
#(
   parameter int addrWidth = 9,
   parameter int dataWidth = 91
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic                 wr,
   input  logic [addrWidth-1:0] addr,
   input  logic [dataWidth-1:0] wdata,
   output logic                 idle,
   output logic                 ack,
   output logic [dataWidth-1:0] rdata,
   kmeans_apb_sequencer_if.master apb
);

   km_eng_e              state, state_nx;
   logic [addrWidth-1:0] addr_q;
   logic [dataWidth-1:0] wdata_q;
   logic                 wr_q;

   logic [addrWidth-1:0] paddr_c;
   logic [dataWidth-1:0] pwdata_c;
   logic                 psel_c, penable_c, pwrite_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ENG_SETUP;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ENG_SETUP && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wr_q    <= wr;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      psel_c    = 1'b0;
      penable_c = 1'b0;
      pwrite_c  = 1'b0;
      paddr_c   = '0;
      pwdata_c  = '0;
      ack       = 1'b0;
      case (state)
         ENG_SETUP: begin
            if (req) begin
               psel_c   = 1'b1;
               pwrite_c = wr;
               paddr_c  = addr;
               pwdata_c = wdata;
               state_nx = ENG_ACCESS;
            end
         end
         ENG_ACCESS: begin
            psel_c    = 1'b1;
            penable_c = 1'b1;
            pwrite_c  = wr_q;
            paddr_c   = addr_q;
            pwdata_c  = wdata_q;
            if (apb.pready) begin
               ack      = 1'b1;
               state_nx = ENG_SETUP;
            end
         end
         default: state_nx = ENG_SETUP;
      endcase
   end

   assign idle        = (state == ENG_SETUP);
   assign rdata       = apb.prdata;
   assign apb.psel    = psel_c;
   assign apb.penable = penable_c;
   assign apb.pwrite  = pwrite_c;
   assign apb.paddr   = paddr_c;
   assign apb.pwdata  = pwdata_c;

endmodule

// File: rtl/kmeans_apb_sequencer.sv
// Autonomous APB programmer for k_means_top: loads centroids and points, fires go,
// waits for the interrupt and streams the final centroids out.
//
//   state      | meaning
//   IDLE       | wait for cfg_start, reject bad N
//   CENT       | write cent_1..cent_8 from the input stream
//   FIRST/LAST | program RAM range 1..N
//   PT_ADDR    | write RAM_addr <- k
//   PT_DATA    | write RAM_data <- next input word
//   GO         | write go <- 1
//   WAIT_IRQ   | wait for a fresh rising edge of interupt
//   RD         | read cent_(j+1)
//   OUT        | present centroid j until res_ready
//   DONE       | one-cycle done pulse
module kmeans_apb_sequencer
   import kmeans_pkg::*;
#(
   parameter int addrWidth     = 9,
   parameter int dataWidth     = 91,
   parameter int centroid_num  = 8,
   parameter int log2_cent_num = 3,
   parameter int count_width   = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_start,
   input  logic [count_width-1:0]   cfg_num_points,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [dataWidth-1:0]     in_data,
   kmeans_apb_sequencer_if.master   apb,
   input  logic                     interupt,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [dataWidth-1:0]     res_data,
   output logic [log2_cent_num-1:0] res_idx,
   output logic                     res_last,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   km_state_e                state, state_nx;
   logic [log2_cent_num-1:0] cnt;
   logic [count_width-1:0]   k;
   logic [count_width-1:0]   n_pts;
   logic                     irq_q;

   logic                     req, wr, ack, eng_idle;
   logic [addrWidth-1:0]     addr;
   logic [dataWidth-1:0]     wdata, rdata;

   logic pts_ok, cent_last, irq_edge;

   assign pts_ok    = (cfg_num_points != '0) &&
                      (cfg_num_points <= count_width'(KM_MAX_POINTS));
   assign cent_last = (cnt == log2_cent_num'(centroid_num - 1));
   // irq_q samples every cycle, so a level already high on entry to WAIT_IRQ never looks like an edge
   assign irq_edge  = interupt & ~irq_q;
   assign in_ready  = (state == S_CENT || state == S_PT_DATA) && eng_idle;
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);

   kmeans_apb_master #(
      .addrWidth (addrWidth),
      .dataWidth (dataWidth)
   ) u_master (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .wr    (wr),
      .addr  (addr),
      .wdata (wdata),
      .idle  (eng_idle),
      .ack   (ack),
      .rdata (rdata),
      .apb   (apb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         k         <= '0;
         n_pts     <= '0;
         irq_q     <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_idx   <= '0;
         res_last  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= state_nx;
         irq_q <= interupt;
         err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  if (pts_ok) begin
                     n_pts <= cfg_num_points;
                     cnt   <= '0;
                     k     <= count_width'(1);
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_CENT: if (ack) cnt <= cent_last ? '0 : cnt + 1'b1;
            S_PT_DATA: if (ack) k <= k + 1'b1;
            S_RD: begin
               if (ack) begin
                  res_valid <= 1'b1;
                  res_data  <= rdata;
                  res_idx   <= cnt;
                  res_last  <= cent_last;
               end
            end
            S_OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  res_last  <= 1'b0;
                  cnt       <= cent_last ? '0 : cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      req      = 1'b0;
      wr       = 1'b1;
      addr     = '0;
      wdata    = '0;
      case (state)
         S_IDLE: if (cfg_start && pts_ok) state_nx = S_CENT;
         S_CENT: begin
            req   = in_valid & in_ready;
            addr  = addrWidth'(REG_CENT1) + addrWidth'(cnt);
            wdata = in_data;
            if (ack && cent_last) state_nx = S_FIRST;
         end
         S_FIRST: begin
            req   = 1'b1;
            addr  = addrWidth'(REG_FIRST_RAM);
            wdata = dataWidth'(1);
            if (ack) state_nx = S_LAST;
         end
         S_LAST: begin
            req   = 1'b1;
            addr  = addrWidth'(REG_LAST_RAM);
            wdata = dataWidth'(n_pts);
            if (ack) state_nx = S_PT_ADDR;
         end
         S_PT_ADDR: begin
            req   = 1'b1;
            addr  = addrWidth'(REG_RAM_ADDR);
            wdata = dataWidth'(k);
            if (ack) state_nx = S_PT_DATA;
         end
         S_PT_DATA: begin
            req   = in_valid & in_ready;
            addr  = addrWidth'(REG_RAM_DATA);
            wdata = in_data;
            if (ack) state_nx = (k == n_pts) ? S_GO : S_PT_ADDR;
         end
         S_GO: begin
            req   = 1'b1;
            addr  = addrWidth'(REG_GO);
            wdata = dataWidth'(1);
            if (ack) state_nx = S_WAIT_IRQ;
         end
         S_WAIT_IRQ: if (irq_edge) state_nx = S_RD;
         S_RD: begin
            req  = 1'b1;
            wr   = 1'b0;
            addr = addrWidth'(REG_CENT1) + addrWidth'(cnt);
            if (ack) state_nx = S_OUT;
         end
         S_OUT: if (res_ready) state_nx = cent_last ? S_DONE : S_RD;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_kmeans_apb_sequencer.sv
// Self-checking bench: APB slave model, input feeder, and a register-log reference model.
module tb_kmeans_apb_sequencer;
   import kmeans_pkg::*;

   localparam int AW = 9;
   localparam int DW = 91;
   localparam int CN = 8;
   localparam int LW = 3;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_start = 1'b0;
   logic [CW-1:0] cfg_num_points = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          interupt = 1'b0;
   logic          res_valid, res_last, busy, done, err;
   logic          res_ready = 1'b0;
   logic [DW-1:0] res_data;
   logic [LW-1:0] res_idx;

   kmeans_apb_sequencer_if #(.addrWidth(AW), .dataWidth(DW)) apb ();

   kmeans_apb_sequencer #(
      .addrWidth(AW), .dataWidth(DW), .centroid_num(CN),
      .log2_cent_num(LW), .count_width(CW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_points(cfg_num_points),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .apb(apb), .interupt(interupt),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_idx(res_idx), .res_last(res_last), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          w;
      int            t;
   } xfer_t;

   xfer_t         log_q[$];
   xfer_t         exp_q[$];
   logic [DW-1:0] in_q[$];
   logic [DW-1:0] cents[CN];
   logic [DW-1:0] pts[$];
   logic [DW-1:0] rd_val[CN];

   // Input feeder: presents the head of in_q, pops it after a handshake edge.
   bit gaps = 1'b0;
   bit hs_q = 1'b0;
   always begin
      @(posedge clk);
      #1;
      if (hs_q && in_q.size() > 0) void'(in_q.pop_front());
      if (in_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
         in_valid = 1'b1;
         in_data  = in_q[0];
      end else begin
         in_valid = 1'b0;
         in_data  = '0;
      end
      @(negedge clk);
      hs_q = in_valid && in_ready && !rst;
   end

   // APB slave: programmable wait states, read data from rd_val, logs completed transfers.
   int            ws = 0;
   bit            ws_rand = 1'b0;
   int            acc_cnt = 0;
   int            cur_ws = 0;
   int            max_en = 0;
   int            min_en = 1000;
   int            proto_err = 0;
   logic [AW-1:0] s_a;
   logic [DW-1:0] s_d;
   logic          s_w;
   always @(negedge clk) begin
      if (apb.psel && !apb.penable) begin
         s_a         = apb.paddr;
         s_d         = apb.pwdata;
         s_w         = apb.pwrite;
         acc_cnt     = 0;
         cur_ws      = ws_rand ? int'($urandom_range(0, 2)) : ws;
         apb.pready  = 1'b0;
         apb.prdata  = '0;
      end else if (apb.psel && apb.penable) begin
         if (apb.paddr !== s_a || apb.pwdata !== s_d || apb.pwrite !== s_w) proto_err++;
         apb.pready = (acc_cnt == cur_ws);
         acc_cnt++;
         if (!apb.pwrite && int'(apb.paddr) >= 2 && int'(apb.paddr) < 2 + CN)
            apb.prdata = rd_val[int'(apb.paddr) - 2];
         else
            apb.prdata = '0;
         if (apb.pready) begin
            log_q.push_back('{a: s_a, d: s_d, w: s_w, t: cyc});
            if (acc_cnt > max_en) max_en = acc_cnt;
            if (acc_cnt < min_en) min_en = acc_cnt;
         end
      end else begin
         apb.pready = 1'b0;
         apb.prdata = '0;
         if (apb.penable) proto_err++;
      end
   end

   // Reference: the register writes a correct run must produce, in order.
   function automatic void build_exp(input int n);
      exp_q.delete();
      for (int i = 0; i < CN; i++) exp_q.push_back('{a: AW'(2 + i), d: cents[i], w: 1'b1, t: 0});
      exp_q.push_back('{a: AW'(12), d: DW'(1), w: 1'b1, t: 0});
      exp_q.push_back('{a: AW'(13), d: DW'(n), w: 1'b1, t: 0});
      for (int kk = 1; kk <= n; kk++) begin
         exp_q.push_back('{a: AW'(10), d: DW'(kk), w: 1'b1, t: 0});
         exp_q.push_back('{a: AW'(11), d: pts[kk - 1], w: 1'b1, t: 0});
      end
      exp_q.push_back('{a: AW'(1), d: DW'(1), w: 1'b1, t: 0});
   endfunction

   function automatic int count_reads();
      int r = 0;
      foreach (log_q[i]) if (!log_q[i].w) r++;
      return r;
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      return DW'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_psel"},      128'(apb.psel),    128'(0));
      chk({tag, "_penable"},   128'(apb.penable), 128'(0));
      chk({tag, "_pwrite"},    128'(apb.pwrite),  128'(0));
      chk({tag, "_paddr"},     128'(apb.paddr),   128'(0));
      chk({tag, "_pwdata"},    128'(apb.pwdata),  128'(0));
      chk({tag, "_in_ready"},  128'(in_ready),    128'(0));
      chk({tag, "_res_valid"}, 128'(res_valid),   128'(0));
      chk({tag, "_res_data"},  128'(res_data),    128'(0));
      chk({tag, "_res_idx"},   128'(res_idx),     128'(0));
      chk({tag, "_res_last"},  128'(res_last),    128'(0));
      chk({tag, "_busy"},      128'(busy),        128'(0));
      chk({tag, "_done"},      128'(done),        128'(0));
      chk({tag, "_err"},       128'(err),         128'(0));
   endtask

   task automatic run_case(input int n, input bit directed, input bit gap, input int wsv,
                           input bit wsr, input int stall_idx, input bit irq_pre,
                           input bit dbl, input bit exact);
      int  t0, lim, j, stall, t_go;
      bit  go_seen;
      for (int i = 0; i < CN; i++) begin
         cents[i]  = directed ? DW'(i + 1) : rnd_word();
         rd_val[i] = directed ? DW'(8'hA0 + i) : rnd_word();
      end
      pts.delete();
      for (int i = 0; i < n; i++) begin
         if (directed && i < 8) pts.push_back(DW'(8'h11 + i));
         else if (directed && i == 8) pts.push_back(DW'({13'd7, 13'd0}));
         else if (directed && i == 9) pts.push_back(DW'({13'd17, 13'd0, 13'd7}));
         else pts.push_back(rnd_word());
      end
      build_exp(n);
      log_q.delete();
      in_q.delete();
      for (int i = 0; i < CN; i++) in_q.push_back(cents[i]);
      foreach (pts[i]) in_q.push_back(pts[i]);
      gaps = gap; ws = wsv; ws_rand = wsr;
      max_en = 0; min_en = 1000; proto_err = 0;
      interupt = irq_pre;
      res_ready = 1'b0;
      @(negedge clk);
      chk("pre_psel", 128'(apb.psel), 128'(0));
      cfg_start = 1'b1;
      cfg_num_points = CW'(n);
      t0 = cyc;
      @(negedge clk);
      cfg_start = 1'b0;
      chk("start_busy", 128'(busy), 128'(1));
      chk("start_err", 128'(err), 128'(0));
      if (exact) chk("first_psel_lat", 128'(apb.psel), 128'(1));
      if (dbl) begin
         repeat (3) @(negedge clk);
         cfg_start = 1'b1;
         cfg_num_points = CW'(3);
         @(negedge clk);
         cfg_start = 1'b0;
         chk("busy_start_err", 128'(err), 128'(0));
         chk("busy_start_busy", 128'(busy), 128'(1));
      end
      go_seen = 1'b0; lim = 0; t_go = 0;
      while (!go_seen && lim < 20000) begin
         @(negedge clk);
         lim++;
         if (log_q.size() > 0 && log_q[$].a == AW'(1) && log_q[$].w) begin
            go_seen = 1'b1;
            t_go = log_q[$].t;
         end
      end
      chk("go_seen", 128'(go_seen), 128'(1));
      chk("log_len", 128'(log_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk($sformatf("wr%0d_addr", i), 128'(log_q[i].a), 128'(exp_q[i].a));
         chk($sformatf("wr%0d_data", i), 128'(log_q[i].d), 128'(exp_q[i].d));
         chk($sformatf("wr%0d_dir", i),  128'(log_q[i].w), 128'(exp_q[i].w));
      end
      chk("apb_stable", 128'(proto_err), 128'(0));
      if (!wsr) begin
         chk("penable_max", 128'(max_en), 128'(wsv + 1));
         chk("penable_min", 128'(min_en), 128'(wsv + 1));
      end
      if (exact) chk("go_done_lat", 128'(t_go - t0), 128'(2 * (11 + 2 * n)));

      if (irq_pre) begin
         repeat (6) @(negedge clk);
         chk("irq_level_no_read", 128'(count_reads()), 128'(0));
         chk("irq_level_no_psel", 128'(apb.psel), 128'(0));
         interupt = 1'b0;
         repeat (3) @(negedge clk);
         chk("irq_low_no_read", 128'(count_reads()), 128'(0));
      end else begin
         repeat (2) @(negedge clk);
      end
      interupt = 1'b1;
      @(negedge clk);
      if (exact) chk("rd_after_irq", 128'({apb.psel, apb.pwrite, apb.paddr}), 128'({1'b1, 1'b0, AW'(2)}));

      j = 0; stall = 0; lim = 0;
      while (j < CN && lim < 5000) begin
         lim++;
         if (res_valid && j == stall_idx && stall < 5) begin
            res_ready = 1'b0;
            stall++;
            chk("stall_data", 128'(res_data), 128'(rd_val[j]));
            chk("stall_idx", 128'(res_idx), 128'(j));
            chk("stall_reads", 128'(count_reads()), 128'(j + 1));
         end else begin
            res_ready = 1'b1;
            if (res_valid) begin
               chk($sformatf("res%0d_idx", j),  128'(res_idx),  128'(j));
               chk($sformatf("res%0d_data", j), 128'(res_data), 128'(rd_val[j]));
               chk($sformatf("res%0d_last", j), 128'(res_last), 128'(j == CN - 1));
               j++;
            end
         end
         @(negedge clk);
      end
      res_ready = 1'b0;
      chk("res_count", 128'(j), 128'(CN));
      chk("done_pulse", 128'(done), 128'(1));
      chk("done_busy", 128'(busy), 128'(0));
      chk("read_count", 128'(count_reads()), 128'(CN));
      @(negedge clk);
      chk("done_low", 128'(done), 128'(0));
      chk("idle_valid", 128'(res_valid), 128'(0));
      interupt = 1'b0;
   endtask

   initial begin
      int lim;
      bit hit;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      cfg_start = 1'b1;
      cfg_num_points = CW'(0);
      @(negedge clk);
      cfg_start = 1'b0;
      chk("n0_err", 128'(err), 128'(1));
      chk("n0_busy", 128'(busy), 128'(0));
      chk("n0_psel", 128'(apb.psel), 128'(0));
      @(negedge clk);
      chk("n0_err_pulse", 128'(err), 128'(0));
      chk("n0_psel_later", 128'(apb.psel), 128'(0));
      cfg_start = 1'b1;
      cfg_num_points = CW'(512);
      @(negedge clk);
      cfg_start = 1'b0;
      chk("n512_err", 128'(err), 128'(1));
      chk("n512_busy", 128'(busy), 128'(0));
      cfg_start = 1'b1;
      cfg_num_points = CW'(511);
      @(negedge clk);
      cfg_start = 1'b0;
      chk("n511_err", 128'(err), 128'(0));
      chk("n511_busy", 128'(busy), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_case(10, 1'b1, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 1'b1);
      run_case(1, 1'b0, 1'b1, 3, 1'b0, 8, 1'b0, 1'b1, 1'b0);
      run_case(int'($urandom_range(2, 20)), 1'b0, 1'b1, 0, 1'b1,
               int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < CN; i++) cents[i] = rnd_word();
      in_q.delete();
      for (int i = 0; i < CN + 6; i++) in_q.push_back(rnd_word());
      gaps = 1'b0; ws = 1; ws_rand = 1'b0;
      @(negedge clk);
      cfg_start = 1'b1;
      cfg_num_points = CW'(6);
      @(negedge clk);
      cfg_start = 1'b0;
      hit = 1'b0; lim = 0;
      while (!hit && lim < 2000) begin
         @(negedge clk);
         lim++;
         if (apb.psel && apb.penable && apb.paddr == AW'(11)) hit = 1'b1;
      end
      chk("pt_data_access_seen", 128'(hit), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("midreset");
      rst = 1'b0;
      in_q.delete();
      repeat (2) @(negedge clk);
      chk("midreset_idle_psel", 128'(apb.psel), 128'(0));

      run_case(int'($urandom_range(1, 12)), 1'b0, 1'b0, 0, 1'b0, 8, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
